// File: rtl/cadder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cadder_seq_ctrl
//  Description : Sequencer for the NOPS-operand carry-save adder. Gathers
//                one operand per beat into a registered operand bank that
//                drives the external adder. After the last operand it waits
//                SETTLE_CYC cycles for the adder tree, then captures the sum
//                and offers it on a valid/ready result port.
//                Optional feature macro: CADDER_CTRL_FLUSH_EN adds a flush
//                input that closes a partially filled frame early.
//  Revision    : 1.0 - initial release
// ============================================================================
module cadder_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int NOPS       = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
`ifdef CADDER_CTRL_FLUSH_EN
  input  logic                       flush,
`endif
  output logic [WIDTH*NOPS-1:0]      add_ops,
  input  logic [WIDTH-1:0]           add_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic [$clog2(NOPS+1)-1:0]  out_count,
  output logic                       busy
);

  // Index/count width holds 0..NOPS; the index parks at NOPS while settling.
  localparam int c_idx_w = $clog2(NOPS + 1);
  localparam int c_cnt_w = $clog2(SETTLE_CYC + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NOPS - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_slot [NOPS];
  logic [WIDTH-1:0]     r_out_sum;
  logic [c_idx_w-1:0]   r_out_count;
  logic                 r_out_valid;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_flush;
  logic                 w_flush_go;
  logic                 w_frame_end;
  logic [c_idx_w-1:0]   w_fill_count;

`ifdef CADDER_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Ready only while filling; reset masks it so nothing is taken during reset.
  assign w_in_ready   = (r_state == S_FILL) & ~rst;
  assign w_accept     = in_valid & w_in_ready;

  // Operands held after this edge, including a beat accepted right now.
  assign w_fill_count = r_idx + c_idx_w'(w_accept);

  // A flush only closes a frame that holds (or is just receiving) an operand.
  assign w_flush_go   = (r_state == S_FILL) & w_flush &
                        ((r_idx != '0) | w_accept);
  assign w_frame_end  = (w_accept & (r_idx == c_last_idx)) | w_flush_go;

  // Sequencer: operand collection, settle wait, result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < NOPS; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            for (int k = 0; k < NOPS; k++) begin
              if (r_idx == c_idx_w'(k)) begin
                r_slot[k] <= in_data;
              end
            end
            r_idx <= w_fill_count;
          end
          if (w_frame_end) begin
            r_cnt       <= c_cnt_w'(SETTLE_CYC);
            r_out_count <= w_fill_count;
            r_state     <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          // The bank has been stable since the closing edge; sample the
          // adder once its tree has had SETTLE_CYC cycles to resolve.
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            r_out_sum   <= add_sum;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end

        S_OUT: begin
          // Clearing the bank here means unwritten slots of the next frame
          // read zero, which is what a short (flushed) frame relies on.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_state     <= S_FILL;
            for (int k = 0; k < NOPS; k++) begin
              r_slot[k] <= '0;
            end
          end
        end

        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  // Flatten the operand bank onto the adder bus, slot k at [k*WIDTH +: WIDTH].
  generate
    for (genvar g = 0; g < NOPS; g++) begin : g_pack
      assign add_ops[g*WIDTH +: WIDTH] = r_slot[g];
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign busy      = (r_state != S_FILL) | (r_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_cadder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cadder_seq_ctrl
//  Description : Self-checking bench for cadder_seq_ctrl. Models the external
//                adder and keeps a frame-level reference (operand queue,
//                remaining settle cycles, pending result) that predicts every
//                output each cycle. Directed frames followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cadder_seq_ctrl;

  localparam int WIDTH      = 8;
  localparam int NOPS       = 8;
  localparam int SETTLE_CYC = 2;
  localparam int CW         = $clog2(NOPS + 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [WIDTH*NOPS-1:0] add_ops;
  logic [WIDTH-1:0]      add_sum;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_sum;
  logic [CW-1:0]         out_count;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: operands of the current frame, settle cycles left,
  // and the pending result.
  logic [WIDTH-1:0] m_ops[$];
  int               m_settle = 0;
  bit               m_rv     = 0;
  int               m_sum    = 0;
  bit               m_acc    = 0;
  int               got[$];

  cadder_seq_ctrl #(
    .WIDTH(WIDTH), .NOPS(NOPS), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef CADDER_CTRL_FLUSH_EN
    .flush(1'b0),
`endif
    .add_ops(add_ops), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // External adder: modulo-2^WIDTH sum of all operand slots.
  always_comb begin
    add_sum = '0;
    for (int k = 0; k < NOPS; k++) begin
      add_sum = add_sum + add_ops[k*WIDTH +: WIDTH];
    end
  end

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the reference, advance it.
  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit r);
    logic [63:0] exp_ops;
    int          s;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
    #1;
    exp_ops = '0;
    foreach (m_ops[k]) exp_ops[k*WIDTH +: WIDTH] = m_ops[k];
    check("in_ready",  64'(in_ready),  64'(!r && m_settle == 0 && !m_rv));
    check("out_valid", 64'(out_valid), 64'(m_rv));
    check("busy",      64'(busy),      64'(m_settle != 0 || m_rv || m_ops.size() != 0));
    check("add_ops",   64'(add_ops),   exp_ops);
    if (m_rv) begin
      check("out_sum",   64'(out_sum),   64'(m_sum));
      check("out_count", 64'(out_count), 64'(NOPS));
    end
    if (out_valid && ordy && !r) got.push_back(int'(out_sum));
    @(posedge clk);
    m_acc = 0;
    if (r) begin
      m_ops.delete();
      m_settle = 0;
      m_rv     = 0;
    end else if (m_rv) begin
      if (ordy) begin
        m_rv = 0;
        m_ops.delete();
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) begin
        s = 0;
        foreach (m_ops[k]) s += int'(m_ops[k]);
        m_sum = s % (1 << WIDTH);
        m_rv  = 1;
      end
    end else if (v) begin
      m_ops.push_back(d);
      m_acc = 1;
      if (m_ops.size() == NOPS) m_settle = SETTLE_CYC;
    end
  endtask

  // Offer one operand until the reference says it was taken (bounded).
  task automatic push(input logic [WIDTH-1:0] d);
    for (int t = 0; t < 40; t++) begin
      cyc(1'b1, d, 1'b1, 1'b0);
      if (m_acc) return;
    end
    check("push_timeout", 64'(1), 64'(0));
  endtask

  // Idle with out_ready high until any pending frame has been handed off.
  task automatic drain();
    for (int t = 0; t < 20; t++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      if (!m_rv && m_settle == 0) return;
    end
    check("drain_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    int hs0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Ascending operands 0..7
    got.delete();
    for (int k = 0; k < NOPS; k++) push(WIDTH'(k));
    drain();
    check("t1_count", 64'(got.size()), 64'(1));
    if (got.size() > 0) check("t1_sum", 64'(got[0]), 64'(28));

    // Two frames back to back
    got.delete();
    for (int k = 0; k < NOPS; k++) push(8'd1);
    push(8'd3);
    for (int k = 1; k < NOPS; k++) push(WIDTH'(k));
    drain();
    check("t2_count", 64'(got.size()), 64'(2));
    if (got.size() > 1) begin
      check("t2_sum0", 64'(got[0]), 64'(8));
      check("t2_sum1", 64'(got[1]), 64'(31));
    end

    // Wrap-around: 8 x 200 = 1600 mod 256
    got.delete();
    for (int k = 0; k < NOPS; k++) push(8'd200);
    drain();
    if (got.size() > 0) check("t3_sum", 64'(got[0]), 64'(64));
    else check("t3_none", 64'(0), 64'(1));

    // Back-pressure with in_valid held
    got.delete();
    for (int k = 0; k < NOPS; k++) push(WIDTH'(k + 1));
    for (int t = 0; t < 10 && !m_rv; t++) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    hs0 = got.size();
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    check("t4_handshakes", 64'(got.size() - hs0), 64'(1));
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    check("t4_accept_after", 64'(m_acc), 64'(1));
    if (got.size() > 0) check("t4_sum", 64'(got[0]), 64'(36));
    cyc(1'b0, '0, 1'b1, 1'b1);

    // Reset mid-frame discards partial operands
    got.delete();
    for (int k = 0; k < 3; k++) push(8'd50);
    cyc(1'b1, 8'd99, 1'b1, 1'b1);
    for (int k = 1; k <= NOPS; k++) push(WIDTH'(k));
    drain();
    if (got.size() > 0) check("t5_sum", 64'(got[0]), 64'(36));
    else check("t5_none", 64'(0), 64'(1));

    // Random traffic
    for (int t = 0; t < 1500; t++) begin
      cyc(1'($urandom_range(0, 9) < 7), WIDTH'($urandom),
          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
